// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-op encodings, LSU state type and legality check
package mem_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    // Unknown encodings and accesses not aligned to their own size are rejected.
    function automatic logic memop_illegal(input logic [2:0] memop, input logic [1:0] addr_lo);
        case (memop)
            MEMOP_B, MEMOP_BU: memop_illegal = 1'b0;
            MEMOP_H, MEMOP_HU: memop_illegal = addr_lo[0];
            MEMOP_W:           memop_illegal = (addr_lo != 2'b00);
            default:           memop_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication/mask and load alignment/extension
module lsu_align
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            memop,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] st_wdata,
    output logic [3:0]            st_wmask,
    output logic [DATA_WIDTH-1:0] ld_data
);

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted  = rdata >> {addr_lo, 3'b000};
        st_wdata = wdata;
        st_wmask = 4'b0000;
        ld_data  = '0;
        case (memop)
            MEMOP_B, MEMOP_BU: begin
                st_wdata = {(DATA_WIDTH/8){wdata[7:0]}};
                st_wmask = 4'b0001 << addr_lo;
                ld_data  = {{(DATA_WIDTH-8){shifted[7] & ~memop[2]}}, shifted[7:0]};
            end
            MEMOP_H, MEMOP_HU: begin
                st_wdata = {(DATA_WIDTH/16){wdata[15:0]}};
                st_wmask = 4'b0011 << addr_lo;
                ld_data  = {{(DATA_WIDTH-16){shifted[15] & ~memop[2]}}, shifted[15:0]};
            end
            MEMOP_W: begin
                st_wmask = 4'b1111;
                ld_data  = shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store unit bridging EX requests to a memory bus
module lsu_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_addr,
    input  logic [2:0]            in_memop,
    input  logic                  in_memwr,
    input  logic                  in_memrd,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    input  logic [4:0]            in_rd,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DATA_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [3:0]            bus_wmask,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic [4:0]            out_rd,
    output logic                  out_err
);

    lsu_state_t            state, state_nxt;
    logic [2:0]            memop_q;
    logic [1:0]            addr_lo_q;
    logic                  req_noop, req_illegal;
    logic [2:0]            al_memop;
    logic [1:0]            al_addr_lo;
    logic [DATA_WIDTH-1:0] st_wdata, ld_data;
    logic [3:0]            st_wmask;

    assign req_noop    = !in_memrd && !in_memwr;
    assign req_illegal = (in_memrd && in_memwr) ||
                         (!req_noop && memop_illegal(in_memop, in_addr[1:0]));

    // Store lanes come from the live request at accept; load extension from the latched one.
    assign al_memop   = (state == IDLE) ? in_memop     : memop_q;
    assign al_addr_lo = (state == IDLE) ? in_addr[1:0] : addr_lo_q;

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .memop    (al_memop),
        .addr_lo  (al_addr_lo),
        .wdata    (in_wdata),
        .rdata    (bus_rdata),
        .st_wdata (st_wdata),
        .st_wmask (st_wmask),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (in_valid) state_nxt = (req_illegal || req_noop) ? RESP : REQ;
            REQ:    if (bus_gnt) state_nxt = bus_we ? RESP : WAIT_R;
            WAIT_R: if (bus_rvalid) state_nxt = RESP;
            RESP:   if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            memop_q   <= '0;
            addr_lo_q <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wmask <= '0;
            out_valid <= 1'b0;
            out_rdata <= '0;
            out_rd    <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    memop_q   <= in_memop;
                    addr_lo_q <= in_addr[1:0];
                    out_rd    <= in_rd;
                    if (req_illegal || req_noop) begin
                        out_valid <= 1'b1;
                        out_rdata <= '0;
                        out_err   <= req_illegal;
                    end else begin
                        bus_req   <= 1'b1;
                        bus_we    <= in_memwr;
                        bus_addr  <= {in_addr[DATA_WIDTH-1:2], 2'b00};
                        bus_wdata <= in_memwr ? st_wdata : '0;
                        bus_wmask <= in_memwr ? st_wmask : 4'b0000;
                    end
                end
                REQ: if (bus_gnt) begin
                    bus_req <= 1'b0;
                    if (bus_we) begin
                        out_valid <= 1'b1;
                        out_rdata <= '0;
                        out_err   <= 1'b0;
                    end
                end
                WAIT_R: if (bus_rvalid) begin
                    out_valid <= 1'b1;
                    out_rdata <= ld_data;
                    out_err   <= 1'b0;
                end
                RESP: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed and randomized bench for lsu_ctrl against a byte-lane model
module tb_lsu_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_memwr, in_memrd;
    logic [31:0] in_addr, in_wdata;
    logic [2:0]  in_memop;
    logic [4:0]  in_rd;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wmask;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;

    int checks = 0;
    int failures = 0;

    lsu_ctrl #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_memop(in_memop),
        .in_memwr(in_memwr), .in_memrd(in_memrd), .in_wdata(in_wdata), .in_rd(in_rd),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wmask(bus_wmask), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int op_size(input logic [2:0] op);
        return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_illegal(input logic [31:0] a, input logic [2:0] op, input logic rd, input logic wr);
        if (rd && wr) return 1'b1;
        if (!rd && !wr) return 1'b0;
        if (!(op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        return (a % op_size(op)) != 0;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wd);
        case (op_size(op))
            1:       return wd[7:0] * 32'h0101_0101;
            2:       return wd[15:0] * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [3:0] model_wmask(input logic [2:0] op, input logic [1:0] off);
        int m;
        m = ((1 << op_size(op)) - 1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] off, input logic [31:0] rdat);
        logic [63:0] v, m;
        int bits;
        bits = 8 * op_size(op);
        v = {32'd0, rdat} >> (8 * off);
        if (bits == 32) return v[31:0];
        m = (64'd1 << bits) - 1;
        v = v & m;
        if (!op[2] && v[bits-1]) v = v | ~m;
        return v[31:0];
    endfunction

    task automatic txn(input logic [31:0] a, input logic [2:0] op, input logic wr, input logic rd,
                       input logic [31:0] wd, input logic [4:0] tag, input int gd,
                       input logic [31:0] rdat, input int rvd, input int rdyd);
        bit          ill, noop;
        logic [31:0] ew, eo;
        logic [3:0]  em;
        ill  = model_illegal(a, op, rd, wr);
        noop = !rd && !wr;
        eo   = 32'd0;
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1; in_addr = a; in_memop = op; in_memwr = wr; in_memrd = rd;
        in_wdata = wd; in_rd = tag;
        tick;
        in_valid = 0; in_addr = $urandom; in_wdata = $urandom; in_rd = 5'($urandom);
        if (ill || noop) begin
            chk("early_valid", out_valid, 1);
            chk("early_err", out_err, 32'(ill));
            chk("early_rdata", out_rdata, 0);
        end else begin
            ew = wr ? model_wdata(op, wd) : 32'd0;
            em = wr ? model_wmask(op, a[1:0]) : 4'd0;
            for (int i = 0; i <= gd; i++) begin
                chk("bus_req_hold", bus_req, 1);
                chk("bus_addr", bus_addr, {a[31:2], 2'b00});
                chk("bus_we", bus_we, 32'(wr));
                chk("bus_wdata", bus_wdata, ew);
                chk("bus_wmask", bus_wmask, 32'(em));
                chk("in_ready_busy", in_ready, 0);
                chk("out_valid_req", out_valid, 0);
                if (i == gd) begin
                    bus_gnt = 1; out_ready = 0; bus_rvalid = 0;
                end else begin
                    out_ready = 1'($urandom); bus_rvalid = 1'($urandom); bus_rdata = $urandom;
                end
                tick;
            end
            bus_gnt = 0; out_ready = 0; bus_rvalid = 0;
            chk("bus_req_drop", bus_req, 0);
            if (!wr) begin
                eo = model_load(op, a[1:0], rdat);
                for (int i = 0; i <= rvd; i++) begin
                    chk("out_valid_wait", out_valid, 0);
                    if (i == rvd) begin
                        bus_rvalid = 1; bus_rdata = rdat; out_ready = 0;
                    end else begin
                        out_ready = 1'($urandom);
                    end
                    tick;
                end
                bus_rvalid = 0; out_ready = 0;
            end
            chk("resp_valid", out_valid, 1);
            chk("resp_err", out_err, 0);
            chk("resp_rdata", out_rdata, eo);
        end
        chk("resp_rd", out_rd, 32'(tag));
        for (int i = 0; i < rdyd; i++) begin
            bus_rvalid = 1'($urandom); bus_rdata = $urandom;
            tick;
            chk("hold_valid", out_valid, 1);
            chk("hold_rdata", out_rdata, eo);
            chk("hold_rd", out_rd, 32'(tag));
            chk("hold_err", out_err, 32'(ill));
            chk("hold_in_ready", in_ready, 0);
            chk("hold_bus_req", bus_req, 0);
        end
        bus_rvalid = 0; out_ready = 1;
        tick;
        out_ready = 0;
        chk("done_valid", out_valid, 0);
        chk("done_in_ready", in_ready, 1);
    endtask

    task automatic chk_reset_outputs;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_bus_wmask", bus_wmask, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_rdata", out_rdata, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_err", out_err, 0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic        wr, rd;
        rst = 1; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; out_ready = 0;
        in_valid = 1; in_addr = 32'h8000_0000; in_memop = MEMOP_W; in_memwr = 0; in_memrd = 1;
        in_wdata = 0; in_rd = 5'd7;
        repeat (3) tick;
        chk_reset_outputs();
        rst = 0; in_valid = 0;

        txn(32'h8000_0003, MEMOP_B, 1, 0, 32'h0000_00A5, 5'd1, 0, 0, 0, 0);
        txn(32'h8000_0002, MEMOP_B, 0, 1, 0, 5'd2, 0, 32'h0080_0000, 0, 0);
        txn(32'h8000_0002, MEMOP_BU, 0, 1, 0, 5'd3, 0, 32'h0080_0000, 0, 1);
        txn(32'h8000_0002, MEMOP_HU, 0, 1, 0, 5'd4, 0, 32'h8001_0000, 1, 0);
        txn(32'h8000_0001, MEMOP_W, 0, 1, 0, 5'd5, 0, 0, 0, 2);
        txn(32'h8000_0000, MEMOP_W, 1, 1, 32'h1234_5678, 5'd6, 0, 0, 0, 1);
        txn(32'h8000_0006, MEMOP_H, 1, 0, 32'hCAFE_BEEF, 5'd7, 5, 0, 0, 3);
        txn(32'h8000_0000, MEMOP_W, 0, 0, 0, 5'd8, 0, 0, 0, 1);

        in_valid = 1; in_addr = 32'h8000_0010; in_memop = MEMOP_W; in_memwr = 0; in_memrd = 1; in_rd = 5'd9;
        tick;
        in_valid = 0; bus_gnt = 1;
        tick;
        bus_gnt = 0; rst = 1;
        tick;
        rst = 0; bus_rvalid = 1; bus_rdata = 32'hDEAD_BEEF;
        chk_reset_outputs();
        tick;
        bus_rvalid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_valid", out_valid, 0);
            chk("post_rst_in_ready", in_ready, 1);
            tick;
        end
        txn(32'h8000_0010, MEMOP_W, 0, 1, 0, 5'd9, 1, 32'h0BAD_F00D, 0, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: op = MEMOP_B;
                1: op = MEMOP_H;
                2: op = MEMOP_W;
                3: op = MEMOP_BU;
                4: op = MEMOP_HU;
                default: op = 3'($urandom_range(6, 8) % 8 == 0 ? 3 : $urandom_range(6, 7));
            endcase
            a  = $urandom;
            wr = 1'($urandom);
            rd = ($urandom_range(0, 9) == 0) ? wr : !wr;
            if ($urandom_range(0, 2) != 0 && op inside {MEMOP_B, MEMOP_H, MEMOP_W, MEMOP_BU, MEMOP_HU})
                a = a & ~32'(op_size(op) - 1);
            if ($urandom_range(0, 11) == 0) begin
                wr = 0; rd = 0; op = MEMOP_W; a = a & ~32'd3;
            end
            txn(a, op, wr, rd, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom,
                $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
